// File: rtl/usb_auth_responder_if.sv
// Driver-facing bundle of the Type-C auth responder: CC levels, request/response buses and handshakes.
interface usb_auth_responder_if #(
  parameter int MSG_LEN = 2080
);
  logic               CC1;
  logic               CC2;
  logic               resp_req_in;
  logic [MSG_LEN-1:0] auth_msg_in;
  logic [7:0]         pending_auth_request;
  logic               Ack_in_driver;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_out;
  logic               auth_msg_ready;
  logic               PD_in_ready;
  logic               DEBUG_in_ready;

  modport master (
    output CC1, CC2, resp_req_in, auth_msg_in, pending_auth_request, Ack_in_driver,
    input  resp_req_out, auth_msg_out, auth_msg_ready, PD_in_ready, DEBUG_in_ready
  );

  modport slave (
    input  CC1, CC2, resp_req_in, auth_msg_in, pending_auth_request, Ack_in_driver,
    output resp_req_out, auth_msg_out, auth_msg_ready, PD_in_ready, DEBUG_in_ready
  );
endinterface

// File: rtl/usb_auth_responder.sv
// Type-C auth responder: debounced attach, one request at a time, payload built one byte per clock.
// Define AUTH_RESP_CHALLENGE_EN to answer CHALLENGE (8'h83) with a nonce-derived payload.
module usb_auth_responder #(
  parameter int MSG_LEN      = 2080,
  parameter int PAY_BITS     = 2016,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input logic                 clk,
  input logic                 reset,
  usb_auth_responder_if.slave bus
);

  localparam int PAY_BYTES = PAY_BITS / 8;
  localparam int IW        = $clog2(MSG_LEN);
  localparam int DW        = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [15:0] PAY_BYTES_W = 16'(PAY_BYTES);

  typedef enum logic [2:0] {
    ST_DETACHED,
    ST_IDLE,
    ST_CAPTURE,
    ST_DECODE,
    ST_BUILD,
    ST_WAIT_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic              deb_cc1_q, deb_cc1_d;
  logic              orient_q, orient_d;
  logic [7:0]        k_q, k_d;
  logic [TW-1:0]     ack_cnt_q, ack_cnt_d;

  logic [7:0]        req_ver_q;
  logic [7:0]        req_type_q;
  logic [1:0]        req_slot_q;
  logic [15:0]       req_off_q;
  logic [15:0]       req_len_q;
  logic [7:0]        n_q;
  logic [MSG_LEN-1:0] msg_out_q;
`ifdef AUTH_RESP_CHALLENGE_EN
  logic [255:0]      nonce_q;
  logic [7:0]        nonce_hi;
`endif

  logic              cc_attached;
  logic              detach;
  logic [3:0]        pop_mask;
  logic              slot_pop;
  logic [7:0]        dec_type;
  logic [7:0]        dec_p1;
  logic [7:0]        dec_p2;
  logic [15:0]       dec_n;
  logic [7:0]        seq_byte;
  logic [7:0]        build_byte;
  logic [IW-1:0]     bhi;
  logic              unused_req_bits;

  assign cc_attached = bus.CC1 ^ bus.CC2;
  assign detach      = (state_q != ST_DETACHED) && !cc_attached;

  // Only the header fields and (optionally) the nonce are kept from the request.
  assign unused_req_bits = ^bus.auth_msg_in;

  // Populated mask is slot-0-first: bit 3 reports slot 0, bit 0 reports slot 3.
  always_comb begin
    pop_mask = '0;
    for (int i = 0; i < 4; i++) begin
      pop_mask[3-i] = |bus.pending_auth_request[2*i +: 2];
    end
  end

  assign slot_pop = |bus.pending_auth_request[{req_slot_q, 1'b0} +: 2];

  always_comb begin
    dec_type = 8'h7F;
    dec_p1   = 8'h05;
    dec_p2   = 8'h00;
    dec_n    = 16'h0000;
    if (req_ver_q != 8'h01) begin
      dec_p1 = 8'h01;
    end else begin
      case (req_type_q)
        8'h81: begin
          dec_type = 8'h01;
          dec_p1   = 8'h00;
          dec_p2   = {4'h0, pop_mask};
        end
        8'h82: begin
          if (!slot_pop) begin
            dec_p1 = 8'h01;
          end else begin
            dec_type = 8'h02;
            dec_p1   = {6'h0, req_slot_q};
            dec_n    = (req_len_q > PAY_BYTES_W) ? PAY_BYTES_W : req_len_q;
          end
        end
`ifdef AUTH_RESP_CHALLENGE_EN
        8'h83: begin
          if (!slot_pop) begin
            dec_p1 = 8'h01;
          end else begin
            dec_type = 8'h03;
            dec_p1   = {6'h0, req_slot_q};
            dec_n    = 16'd32;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign seq_byte = req_off_q[7:0] + k_q;
  assign bhi      = IW'(PAY_BITS - 1) - IW'({k_q, 3'b000});
`ifdef AUTH_RESP_CHALLENGE_EN
  assign nonce_hi = 8'd255 - {k_q[4:0], 3'b000};
`endif

  // Only successful certificate/challenge requests ever reach BUILD.
  always_comb begin
    build_byte = seq_byte ^ {6'h0, req_slot_q};
`ifdef AUTH_RESP_CHALLENGE_EN
    if (req_type_q == 8'h83) begin
      build_byte = nonce_q[nonce_hi -: 8] ^ seq_byte;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_DETACHED;
      deb_cnt_q <= '0;
      deb_cc1_q <= 1'b0;
      orient_q  <= 1'b0;
      k_q       <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      deb_cc1_q <= deb_cc1_d;
      orient_q  <= orient_d;
      k_q       <= k_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    deb_cc1_d = deb_cc1_q;
    orient_d  = orient_q;
    k_d       = k_q;
    ack_cnt_d = ack_cnt_q;
    if (state_q == ST_DETACHED) begin
      // An orientation flip during debounce restarts the count.
      if (!cc_attached) begin
        deb_cnt_d = '0;
      end else if ((deb_cnt_q != '0) && (bus.CC1 != deb_cc1_q)) begin
        deb_cnt_d = DW'(1);
        deb_cc1_d = bus.CC1;
      end else if (deb_cnt_q == DW'(DEBOUNCE_CYC)) begin
        state_d   = ST_IDLE;
        orient_d  = deb_cc1_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
        deb_cc1_d = bus.CC1;
      end
    end else if (detach) begin
      state_d   = ST_DETACHED;
      deb_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.resp_req_in) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: state_d = ST_DECODE;
        ST_DECODE: begin
          k_d       = '0;
          ack_cnt_d = '0;
          state_d   = (n_q == 8'd0) ? ST_WAIT_ACK : ST_BUILD;
        end
        ST_BUILD: begin
          k_d = k_q + 8'd1;
          if (k_q == n_q - 8'd1) state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.Ack_in_driver || (ack_cnt_q == TW'(ACK_TIMEOUT - 1))) begin
            state_d = ST_IDLE;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_DETACHED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ver_q  <= '0;
      req_type_q <= '0;
      req_slot_q <= '0;
      req_off_q  <= '0;
      req_len_q  <= '0;
      n_q        <= '0;
      msg_out_q  <= '0;
`ifdef AUTH_RESP_CHALLENGE_EN
      nonce_q    <= '0;
`endif
    end else if (detach) begin
      msg_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.resp_req_in) begin
            req_ver_q  <= bus.auth_msg_in[MSG_LEN-1  -: 8];
            req_type_q <= bus.auth_msg_in[MSG_LEN-9  -: 8];
            req_slot_q <= bus.auth_msg_in[MSG_LEN-23 -: 2];
            req_off_q  <= bus.auth_msg_in[MSG_LEN-33 -: 16];
            req_len_q  <= bus.auth_msg_in[MSG_LEN-49 -: 16];
`ifdef AUTH_RESP_CHALLENGE_EN
            nonce_q    <= bus.auth_msg_in[PAY_BITS-1 -: 256];
`endif
          end
        end
        ST_CAPTURE: begin
          msg_out_q <= {8'h01, dec_type, dec_p1, dec_p2, req_off_q, dec_n, {PAY_BITS{1'b0}}};
          n_q       <= dec_n[7:0];
        end
        ST_BUILD: msg_out_q[bhi -: 8] <= build_byte;
        default: ;
      endcase
    end
  end

  assign bus.auth_msg_out   = msg_out_q;
  assign bus.resp_req_out   = (state_q == ST_CAPTURE);
  assign bus.auth_msg_ready = (state_q == ST_WAIT_ACK);
  assign bus.PD_in_ready    = (state_q == ST_IDLE) && orient_q;
  assign bus.DEBUG_in_ready = (state_q == ST_IDLE) && !orient_q;

endmodule

// File: tb/tb_usb_auth_responder.sv
// Bench for usb_auth_responder: directed protocol steps plus randomized requests scored against a byte-level model.
module tb_usb_auth_responder;

  localparam int MSG_LEN   = 2080;
  localparam int PAY_BITS  = 2016;
  localparam int PAY_BYTES = 252;
`ifdef AUTH_RESP_CHALLENGE_EN
  localparam bit CHAL_EN = 1'b1;
`else
  localparam bit CHAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  usb_auth_responder_if #(.MSG_LEN(MSG_LEN)) bus ();

  usb_auth_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_pay(input string tag, input logic [MSG_LEN-1:0] obs, input logic [MSG_LEN-1:0] exp);
    int bad = 0;
    for (int k = PAY_BYTES - 1; k >= 0; k--) begin
      if (obs[PAY_BITS-1-8*k -: 8] !== exp[PAY_BITS-1-8*k -: 8]) bad = k;
    end
    n_checks++;
    assert (obs[PAY_BITS-1:0] === exp[PAY_BITS-1:0]) n_pass++;
    else $error("FAIL %s: payload byte %0d observed %h expected %h", tag, bad,
                obs[PAY_BITS-1-8*bad -: 8], exp[PAY_BITS-1-8*bad -: 8]);
  endtask

  function automatic logic [MSG_LEN-1:0] make_req(input logic [7:0] ver, input logic [7:0] typ,
                                                  input logic [7:0] p1, input logic [15:0] off,
                                                  input logic [15:0] len);
    logic [MSG_LEN-1:0] r;
    r = '0;
    for (int w = 0; w < PAY_BITS / 32; w++) r[32*w +: 32] = $urandom();
    r[MSG_LEN-1 -: 64] = {ver, typ, p1, 8'($urandom()), off, len};
    return r;
  endfunction

  // Response expected from the protocol rules; care masks out header bytes the rules leave open.
  function automatic void model(input logic [MSG_LEN-1:0] req, input logic [7:0] pend,
                                output logic [MSG_LEN-1:0] exp, output logic [63:0] care,
                                output int n);
    logic [7:0]  ver, typ, p1, rtyp, rp1, rp2, mask, b;
    logic [15:0] off, len;
    int          slot;
    ver  = req[MSG_LEN-1 -: 8];
    typ  = req[MSG_LEN-9 -: 8];
    p1   = req[MSG_LEN-17 -: 8];
    off  = req[MSG_LEN-33 -: 16];
    len  = req[MSG_LEN-49 -: 16];
    slot = int'(p1[1:0]);
    mask = 8'h00;
    for (int i = 0; i < 4; i++) if (pend[2*i +: 2] != 2'b00) mask[3-i] = 1'b1;
    rtyp = 8'h7F; rp1 = 8'h05; rp2 = 8'h00; n = 0;
    care = {24'hFFFFFF, 8'h00, 32'hFFFFFFFF};
    if (ver != 8'h01) begin
      rp1 = 8'h01;
    end else if (typ == 8'h81) begin
      rtyp = 8'h01; rp2 = mask;
      care = {16'hFFFF, 16'h00FF, 32'hFFFFFFFF};
    end else if (typ == 8'h82 || (CHAL_EN && typ == 8'h83)) begin
      if (!mask[3-slot]) rp1 = 8'h01;
      else begin
        rtyp = (typ == 8'h82) ? 8'h02 : 8'h03;
        rp1  = 8'(slot);
        n    = (typ == 8'h82) ? ((len > 16'd252) ? 252 : int'(len)) : 32;
      end
    end
    exp = '0;
    exp[MSG_LEN-1 -: 64] = {8'h01, rtyp, rp1, rp2, off, 16'(n)};
    for (int k = 0; k < n; k++) begin
      b = 8'(int'(off[7:0]) + k);
      if (typ == 8'h83) b = b ^ req[PAY_BITS-1-8*k -: 8];
      else b = b ^ 8'(slot);
      exp[PAY_BITS-1-8*k -: 8] = b;
    end
  endfunction

  logic [MSG_LEN-1:0] last_exp;
  logic [63:0]        last_care;

  // Issues one request and returns at the edge where auth_msg_ready rises (or the bound expires).
  task automatic issue(input string tag, input logic [MSG_LEN-1:0] req, input bit keep);
    int edges;
    int n;
    model(req, bus.pending_auth_request, last_exp, last_care, n);
    @(negedge clk);
    bus.auth_msg_in = req;
    bus.resp_req_in = 1'b1;
    @(posedge clk); #1;
    check({tag, "_req_pulse"}, 64'(bus.resp_req_out), 64'd1);
    if (!keep) bus.resp_req_in = 1'b0;
    @(posedge clk); #1;
    edges = 1;
    check({tag, "_req_pulse_end"}, 64'(bus.resp_req_out), 64'd0);
    check({tag, "_busy_not_ready"}, 64'(bus.PD_in_ready | bus.DEBUG_in_ready), 64'd0);
    while (!bus.auth_msg_ready && edges < 400) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(2 + n));
    check({tag, "_hdr"}, bus.auth_msg_out[MSG_LEN-1 -: 64] & last_care, last_exp[MSG_LEN-1 -: 64] & last_care);
    check_pay({tag, "_pay"}, bus.auth_msg_out, last_exp);
  endtask

  task automatic finish_ack(input string tag);
    @(negedge clk);
    bus.Ack_in_driver = 1'b1;
    @(posedge clk); #1;
    bus.Ack_in_driver = 1'b0;
    check({tag, "_ack_drop"}, 64'(bus.auth_msg_ready), 64'd0);
    check({tag, "_idle_again"}, 64'(bus.PD_in_ready | bus.DEBUG_in_ready), 64'd1);
  endtask

  initial begin
    logic [MSG_LEN-1:0] req;
    int edges;
    int pick;

    reset = 1'b1;
    bus.CC1 = 1'b0; bus.CC2 = 1'b0;
    bus.resp_req_in = 1'b0; bus.auth_msg_in = '0;
    bus.pending_auth_request = 8'h00; bus.Ack_in_driver = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.resp_req_out, bus.auth_msg_ready, bus.PD_in_ready, bus.DEBUG_in_ready}), 64'd0);
    check("reset_msg_zero", 64'(bus.auth_msg_out != '0), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Attach with CC1 orientation: ready on the fifth edge.
    @(negedge clk);
    bus.CC1 = 1'b1; bus.CC2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("attach_edge4", 64'(bus.PD_in_ready), 64'd0);
    @(posedge clk); #1;
    check("attach_pd", 64'(bus.PD_in_ready), 64'd1);
    check("attach_debug", 64'(bus.DEBUG_in_ready), 64'd0);
    @(negedge clk);
    bus.CC1 = 1'b0;
    @(posedge clk); #1;
    check("detach_pd", 64'(bus.PD_in_ready), 64'd0);
    @(negedge clk);
    bus.CC1 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reattach_pd", 64'(bus.PD_in_ready), 64'd1);

    // Slots 0, 2, 3 populated.
    bus.pending_auth_request = 8'b0110_0011;
    req = make_req(8'h01, 8'h82, 8'h00, 16'($urandom()), 16'h0103);
    issue("cert_full", req, 1'b0);
    check("cert_full_len", 64'(bus.auth_msg_out[MSG_LEN-49 -: 16]), 64'h00FC);
    finish_ack("cert_full");

    req = make_req(8'h01, 8'h82, 8'h00, 16'($urandom()), 16'h0095);
    issue("cert_149", req, 1'b0);
    check("cert_149_len", 64'(bus.auth_msg_out[MSG_LEN-49 -: 16]), 64'h0095);
    check("cert_149_tail_zero", 64'(bus.auth_msg_out[PAY_BITS-1-8*149:0] != '0), 64'd0);
    finish_ack("cert_149");

    // Digests with resp_req_in held high: a second capture follows the ack immediately.
    req = make_req(8'h01, 8'h81, 8'($urandom()), 16'($urandom()), 16'($urandom()));
    issue("digests", req, 1'b1);
    check("digests_type", 64'(bus.auth_msg_out[MSG_LEN-9 -: 8]), 64'h01);
    check("digests_p2", 64'(bus.auth_msg_out[MSG_LEN-25 -: 8]), 64'h0B);
    finish_ack("digests");
    @(posedge clk); #1;
    check("recapture_pulse", 64'(bus.resp_req_out), 64'd1);
    bus.resp_req_in = 1'b0;
    edges = 0;
    while (!bus.auth_msg_ready && edges < 400) begin
      @(posedge clk); #1;
      edges++;
    end
    check("recapture_latency", 64'(edges), 64'd2);
    check("recapture_hdr", bus.auth_msg_out[MSG_LEN-1 -: 64] & last_care, last_exp[MSG_LEN-1 -: 64] & last_care);
    finish_ack("recapture");

    // Bad version, then let the ack time out.
    req = make_req(8'h02, 8'h82, 8'h00, 16'($urandom()), 16'h0010);
    issue("bad_ver", req, 1'b0);
    edges = 0;
    while (bus.auth_msg_ready && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    check("timeout_cycles", 64'(edges), 64'd255);
    check("timeout_retained", bus.auth_msg_out[MSG_LEN-1 -: 64] & last_care, last_exp[MSG_LEN-1 -: 64] & last_care);
    check("timeout_idle", 64'(bus.PD_in_ready), 64'd1);

    req = make_req(8'h01, 8'h83, 8'h00, 16'($urandom()), 16'($urandom()));
    issue("challenge", req, 1'b0);
    finish_ack("challenge");

    for (int it = 0; it < 20; it++) begin
      logic [7:0]  ver, typ;
      logic [15:0] len;
      bus.pending_auth_request = 8'($urandom());
      pick = $urandom_range(0, 9);
      ver  = (pick == 9) ? 8'($urandom()) : 8'h01;
      typ  = (pick < 3) ? 8'h81 : (pick < 7) ? 8'h82 : (pick == 7) ? 8'h83 : 8'($urandom());
      len  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom());
      req  = make_req(ver, typ, 8'($urandom()), 16'($urandom()), len);
      issue("rand", req, 1'b0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      finish_ack("rand");
    end

    // Detach in the middle of a long build.
    bus.pending_auth_request = 8'b0000_0011;
    req = make_req(8'h01, 8'h82, 8'h00, 16'($urandom()), 16'hFFFF);
    @(negedge clk);
    bus.auth_msg_in = req;
    bus.resp_req_in = 1'b1;
    @(posedge clk); #1;
    bus.resp_req_in = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    bus.CC1 = 1'b1; bus.CC2 = 1'b1;
    @(posedge clk); #1;
    check("midbuild_detach_outputs", 64'({bus.resp_req_out, bus.auth_msg_ready, bus.PD_in_ready, bus.DEBUG_in_ready}), 64'd0);
    check("midbuild_detach_msg", 64'(bus.auth_msg_out != '0), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("midbuild_stays_detached", 64'(bus.auth_msg_ready | bus.PD_in_ready | bus.DEBUG_in_ready), 64'd0);

    @(negedge clk);
    bus.CC1 = 1'b0; bus.CC2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("debug_attach_edge4", 64'(bus.DEBUG_in_ready), 64'd0);
    @(posedge clk); #1;
    check("debug_attach", 64'(bus.DEBUG_in_ready), 64'd1);
    check("debug_attach_pd", 64'(bus.PD_in_ready), 64'd0);
    req = make_req(8'h01, 8'h82, 8'h00, 16'($urandom()), 16'($urandom_range(1, 40)));
    issue("debug_cert", req, 1'b0);
    finish_ack("debug_cert");
    check("debug_idle", 64'(bus.DEBUG_in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
